// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that turns single AHB transfers into APB3 transfers.
// One transfer in flight at a time; all bus-facing outputs come straight from registers.
module ahb_apb_bridge #(
    parameter int PADDR_W = 16
) (
    input  logic               HCLK,
    input  logic               HRESTn,
    input  logic               HSELx,
    input  logic [31:0]        HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [1:0]         HTRANS,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [PADDR_W-1:0] PADDR,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    state_t             state_q;
    logic [PADDR_W-1:0] paddr_q;
    logic               pwrite_q;
    logic [31:0]        pwdata_q;
    logic               psel_q;
    logic               penable_q;
    logic               hreadyout_q;
    logic               hresp_q;
    logic [31:0]        hrdata_q;

    logic accept;
    logic badSize;
    logic unusedBits;

    assign accept     = HSELx & HREADY & HTRANS[1];
    assign badSize    = (HSIZE > 3'd2);
    assign unusedBits = ^{HTRANS[0], HADDR};

    // ERR2 doubles as an address phase, so it shares the accept path with IDLE.
    always_ff @(posedge HCLK) begin
        if (HRESTn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE, ERR2: begin
                    if (accept) begin
                        paddr_q     <= HADDR[PADDR_W-1:0];
                        pwrite_q    <= HWRITE;
                        hreadyout_q <= 1'b0;
                        if (badSize) begin
                            state_q <= ERR1;
                            hresp_q <= 1'b1;
                        end else if (HWRITE) begin
                            state_q <= WDATA;
                            hresp_q <= 1'b0;
                        end else begin
                            state_q <= SETUP;
                            hresp_q <= 1'b0;
                            psel_q  <= 1'b1;
                        end
                    end else begin
                        state_q     <= IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                WDATA: begin
                    pwdata_q <= HWDATA;
                    psel_q   <= 1'b1;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // Address, direction and write data stay frozen until PREADY.
                    if (PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (PSLVERR) begin
                            state_q <= ERR1;
                            hresp_q <= 1'b1;
                        end else begin
                            state_q     <= IDLE;
                            hreadyout_q <= 1'b1;
                            if (!pwrite_q) begin
                                hrdata_q <= PRDATA;
                            end
                        end
                    end
                end
                ERR1: begin
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                    state_q     <= ERR2;
                end
                default: begin
                    state_q     <= IDLE;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge; each cycle window opens 1ns after
// the rising edge, where outputs are checked and the next inputs are driven.
module tb_ahb_apb_bridge;

    localparam int PADDR_W = 16;

    logic               HCLK;
    logic               HRESTn;
    logic               HSELx;
    logic [31:0]        HADDR;
    logic               HWRITE;
    logic [2:0]         HSIZE;
    logic [1:0]         HTRANS;
    logic [31:0]        HWDATA;
    logic               HREADY;
    logic [31:0]        HRDATA;
    logic               HREADYOUT;
    logic               HRESP;
    logic [PADDR_W-1:0] PADDR;
    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [31:0]        PWDATA;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    int assertCount = 0;
    int failCount   = 0;

    ahb_apb_bridge #(.PADDR_W(PADDR_W)) dut (
        .HCLK(HCLK), .HRESTn(HRESTn), .HSELx(HSELx), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic nextCycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic sel, input logic [31:0] addr, input logic write,
                                 input logic [2:0] size, input logic [1:0] trans);
        HSELx  = sel;
        HADDR  = addr;
        HWRITE = write;
        HSIZE  = size;
        HTRANS = trans;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        HRESTn = 1'b1;
        HWDATA = '0;
        HREADY = 1'b1;
        PRDATA = '0;
        PREADY = 1'b1;
        PSLVERR = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        nextCycle();
        nextCycle();
        checkOutput("rst_hreadyout", HREADYOUT, 1);
        checkOutput("rst_hresp", HRESP, 0);
        checkOutput("rst_hrdata", HRDATA, 0);
        checkOutput("rst_psel", PSEL, 0);
        checkOutput("rst_penable", PENABLE, 0);
        checkOutput("rst_pwrite", PWRITE, 0);
        checkOutput("rst_paddr", PADDR, 0);
        checkOutput("rst_pwdata", PWDATA, 0);
        HRESTn = 1'b0;
        nextCycle();

        // Write, zero-wait slave: PSEL at T2, PENABLE at T3, HREADYOUT back at T4.
        applyStimulus(1'b1, 32'h0000_0010, 1'b1, 3'd2, 2'd2);
        nextCycle();
        checkOutput("wr_t1_hreadyout", HREADYOUT, 0);
        checkOutput("wr_t1_psel", PSEL, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        HWDATA = 32'hA5A5_0001;
        nextCycle();
        HWDATA = 32'h0;
        checkOutput("wr_t2_psel", PSEL, 1);
        checkOutput("wr_t2_penable", PENABLE, 0);
        checkOutput("wr_t2_hreadyout", HREADYOUT, 0);
        nextCycle();
        checkOutput("wr_t3_psel", PSEL, 1);
        checkOutput("wr_t3_penable", PENABLE, 1);
        checkOutput("wr_t3_paddr", PADDR, 32'h0010);
        checkOutput("wr_t3_pwrite", PWRITE, 1);
        checkOutput("wr_t3_pwdata", PWDATA, 32'hA5A5_0001);
        nextCycle();
        checkOutput("wr_t4_hreadyout", HREADYOUT, 1);
        checkOutput("wr_t4_hresp", HRESP, 0);
        checkOutput("wr_t4_psel", PSEL, 0);
        checkOutput("wr_t4_penable", PENABLE, 0);
        checkOutput("wr_t4_hrdata", HRDATA, 0);

        // Read with three APB wait cycles.
        applyStimulus(1'b1, 32'h0000_0024, 1'b0, 3'd2, 2'd2);
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        checkOutput("rdw_t1_psel", PSEL, 1);
        checkOutput("rdw_t1_penable", PENABLE, 0);
        checkOutput("rdw_t1_hreadyout", HREADYOUT, 0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("rdw_acc%0d_paddr", i), PADDR, 32'h0024);
            checkOutput($sformatf("rdw_acc%0d_psel", i), PSEL, 1);
            checkOutput($sformatf("rdw_acc%0d_penable", i), PENABLE, 1);
            checkOutput($sformatf("rdw_acc%0d_pwrite", i), PWRITE, 0);
            checkOutput($sformatf("rdw_acc%0d_hreadyout", i), HREADYOUT, 0);
            if (i == 3) PREADY = 1'b1;
        end
        nextCycle();
        checkOutput("rdw_t6_hreadyout", HREADYOUT, 1);
        checkOutput("rdw_t6_hrdata", HRDATA, 32'h1234_5678);
        checkOutput("rdw_t6_hresp", HRESP, 0);
        checkOutput("rdw_t6_psel", PSEL, 0);

        // Read answered with PSLVERR: two-cycle ERROR response, HRDATA untouched.
        applyStimulus(1'b1, 32'h0000_0030, 1'b0, 3'd2, 2'd2);
        PSLVERR = 1'b1;
        PRDATA  = 32'hDEAD_BEEF;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        nextCycle();
        checkOutput("err_t2_penable", PENABLE, 1);
        nextCycle();
        PSLVERR = 1'b0;
        checkOutput("err_e1_hreadyout", HREADYOUT, 0);
        checkOutput("err_e1_hresp", HRESP, 1);
        checkOutput("err_e1_psel", PSEL, 0);
        checkOutput("err_e1_penable", PENABLE, 0);
        checkOutput("err_e1_hrdata", HRDATA, 32'h1234_5678);
        nextCycle();
        checkOutput("err_e2_hreadyout", HREADYOUT, 1);
        checkOutput("err_e2_hresp", HRESP, 1);
        nextCycle();
        checkOutput("err_idle_hresp", HRESP, 0);
        checkOutput("err_idle_hreadyout", HREADYOUT, 1);

        // Oversized write never reaches APB.
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 3'd3, 2'd2);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        HWDATA = 32'h5555_AAAA;
        checkOutput("sz_e1_hreadyout", HREADYOUT, 0);
        checkOutput("sz_e1_hresp", HRESP, 1);
        checkOutput("sz_e1_psel", PSEL, 0);
        nextCycle();
        checkOutput("sz_e2_hreadyout", HREADYOUT, 1);
        checkOutput("sz_e2_hresp", HRESP, 1);
        checkOutput("sz_e2_psel", PSEL, 0);
        nextCycle();
        checkOutput("sz_idle_hresp", HRESP, 0);
        checkOutput("sz_idle_psel", PSEL, 0);
        checkOutput("sz_idle_pwdata", PWDATA, 32'hA5A5_0001);

        // Back-to-back: the write is presented in the cycle the read completes.
        applyStimulus(1'b1, 32'h0000_0004, 1'b0, 3'd2, 2'd2);
        PRDATA = 32'hCAFE_0004;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        nextCycle();
        nextCycle();
        checkOutput("b2b_rd_hreadyout", HREADYOUT, 1);
        checkOutput("b2b_rd_hrdata", HRDATA, 32'hCAFE_0004);
        applyStimulus(1'b1, 32'h0000_0008, 1'b1, 3'd2, 2'd2);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        HWDATA = 32'h0BAD_0008;
        checkOutput("b2b_wd_hreadyout", HREADYOUT, 0);
        checkOutput("b2b_wd_psel", PSEL, 0);
        nextCycle();
        HWDATA = 32'h0;
        checkOutput("b2b_setup_psel", PSEL, 1);
        checkOutput("b2b_setup_paddr", PADDR, 32'h0008);
        checkOutput("b2b_setup_pwrite", PWRITE, 1);
        checkOutput("b2b_setup_pwdata", PWDATA, 32'h0BAD_0008);
        nextCycle();
        checkOutput("b2b_acc_penable", PENABLE, 1);
        nextCycle();
        checkOutput("b2b_done_hreadyout", HREADYOUT, 1);
        checkOutput("b2b_done_hrdata", HRDATA, 32'hCAFE_0004);

        // Non-accepted address phases: BUSY, deselected, IDLE, HREADY low.
        applyStimulus(1'b1, 32'h0000_0060, 1'b0, 3'd2, 2'd1);
        nextCycle();
        checkOutput("busy_psel", PSEL, 0);
        checkOutput("busy_hreadyout", HREADYOUT, 1);
        applyStimulus(1'b0, 32'h0000_0064, 1'b1, 3'd2, 2'd2);
        nextCycle();
        checkOutput("nosel_hreadyout", HREADYOUT, 1);
        checkOutput("nosel_paddr", PADDR, 32'h0008);
        applyStimulus(1'b1, 32'h0000_0068, 1'b0, 3'd2, 2'd0);
        nextCycle();
        checkOutput("idle_psel", PSEL, 0);
        checkOutput("idle_hresp", HRESP, 0);
        applyStimulus(1'b1, 32'h0000_006C, 1'b0, 3'd2, 2'd2);
        HREADY = 1'b0;
        nextCycle();
        HREADY = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        checkOutput("nrdy_psel", PSEL, 0);
        checkOutput("nrdy_hreadyout", HREADYOUT, 1);
        nextCycle();
        checkOutput("nrdy_psel2", PSEL, 0);

        // Reset while stalled in ACCESS.
        applyStimulus(1'b1, 32'h0000_0050, 1'b0, 3'd2, 2'd2);
        PREADY = 1'b0;
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd2, 2'd0);
        nextCycle();
        checkOutput("mrst_pre_psel", PSEL, 1);
        checkOutput("mrst_pre_penable", PENABLE, 1);
        HRESTn = 1'b1;
        nextCycle();
        checkOutput("mrst_psel", PSEL, 0);
        checkOutput("mrst_penable", PENABLE, 0);
        checkOutput("mrst_hreadyout", HREADYOUT, 1);
        checkOutput("mrst_hresp", HRESP, 0);
        checkOutput("mrst_hrdata", HRDATA, 0);
        checkOutput("mrst_paddr", PADDR, 0);
        nextCycle();
        HRESTn = 1'b0;
        PREADY = 1'b1;
        nextCycle();
        checkOutput("mrst_after_psel", PSEL, 0);
        checkOutput("mrst_after_hreadyout", HREADYOUT, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- AHB-Lite slave that converts single AHB transfers into APB3 transfers.
- Sits beside the RAM/ROM slaves on the system bus: it gets its own decoder HSELx output and returns HRDATA/HREADYOUT/HRESP through the response mux.
- Downstream it drives one APB peripheral port.
- Registered outputs; one transfer in flight at a time.

Parameters:
PADDR_W, 16, width of PADDR; taken from HADDR[PADDR_W-1:0]

Ports:
HCLK  input  1  clock, rising edge
HRESTn  input  1  reset, synchronous, active-high (1 = reset)
HSELx  input  1  slave select from decoder
HADDR  input  32  AHB address
HWRITE  input  1  1 = write
HSIZE  input  3  transfer size
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus-level ready
HRDATA  output  32  read data
HREADYOUT  output  1  slave ready
HRESP  output  1  0 = OKAY, 1 = ERROR
PADDR  output  PADDR_W  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- Reset values: state IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; PSEL=0; PENABLE=0; PWRITE=0; PADDR=0; PWDATA=0.
- Reset mid-transfer: all of the above apply on the next edge, and PSEL drops immediately regardless of PREADY.
- Accept condition: HSELx & HREADY & HTRANS[1], evaluated only in states IDLE and ERR2.
  - On accept, register HADDR[PADDR_W-1:0] into PADDR and HWRITE into PWRITE.
  - HTRANS IDLE/BUSY, or HSELx=0: no action; HREADYOUT stays 1, HRESP stays 0.
- HSIZE > 2 on an accepted transfer: no APB access; go directly to ERR1.
- HBURST is ignored; every SEQ beat is handled as an independent transfer.
- States and transitions:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted write -> WDATA; accepted read -> SETUP; bad size -> ERR1.
  - WDATA: HREADYOUT=0. Register HWDATA into PWDATA -> SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0 -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. PADDR, PWRITE and PWDATA are held stable.
    - PREADY=0: stay in ACCESS (unbounded wait).
    - PREADY=1 & PSLVERR=0: capture PRDATA into HRDATA (reads only; HRDATA is held on writes); next cycle IDLE with HREADYOUT=1.
    - PREADY=1 & PSLVERR=1: -> ERR1.
  - ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Evaluates accept exactly like IDLE; otherwise -> IDLE.
- PSEL and PENABLE are deasserted on the edge after PREADY=1 is sampled; there are no back-to-back ACCESS cycles.
- Latency with a zero-wait APB slave:
  - Read: address phase T0; SETUP T1; ACCESS T2; HREADYOUT=1 with HRDATA valid at T3.
  - Write: one extra cycle (WDATA), so HREADYOUT=1 at T4.
  - Each APB wait cycle adds one cycle.
- The cycle in which HREADYOUT returns to 1 is also the next address phase. A pipelined transfer presented there is accepted with no bubble.
- HRESP is 0 in every state except ERR1/ERR2. HREADYOUT=0 never coincides with HRESP=0 in the ERR states.

Test Plan:
- Reset: assert HRESTn=1 for 2 cycles during an ACCESS with PREADY=0 -> next edge PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0, HRDATA=0.
- Write 0xA5A5_0001 to HADDR 0x0000_0010, PREADY tied 1 -> PSEL=1 at T2, PENABLE=1 at T3 with PADDR=0x0010, PWRITE=1, PWDATA=0xA5A5_0001; HREADYOUT=1 at T4, HRESP=0.
- Read HADDR 0x0000_0024, PRDATA=0x1234_5678, PREADY low for 3 ACCESS cycles -> PADDR stable for all 4 ACCESS cycles; HRDATA=0x1234_5678 with HREADYOUT=1 at T6.
- Read with PREADY=1, PSLVERR=1 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
- HSIZE=3 write -> no PSEL pulse; two-cycle ERROR response as above.
- Back-to-back: NONSEQ read to 0x4, then NONSEQ write to 0x8 presented in the cycle HREADYOUT returns to 1 -> second transfer accepted with no idle cycle. HTRANS=BUSY or HSELx=0 cycles -> no PSEL, HREADYOUT stays 1.
